dmem_wait: RTL and testbench

Parametrised data memory with a synchronous read/write request port, byte/half/word access sizes, little-endian byte lanes and load sign/zero extension. It has a configurable number of wait states and alignment and range fault reporting. It is the next-generation data memory behind the datapath's load/store unit: the stage holding a load/store waits on `ready` instead of assuming single-cycle access.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_wait_if.sv | 24 ++
 rtl/dmem_lane.sv | 37 +++
 rtl/dmem_wait.sv | 108 ++++++++++
 tb/tb_dmem_wait.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the wait-state data memory.
package dmem_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Size encoding 11 is never aligned, so it surfaces as a misalignment fault.
  function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~addr[0];
      SZ_WORD: return (addr == 2'b00);
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/dmem_wait_if.sv
// Request/response bundle between the load/store unit and the data memory.
interface dmem_wait_if;
  import dmem_pkg::*;
  logic              read;
  logic              write;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic [WORD_W-1:0] address;
  logic [WORD_W-1:0] memIn;
  logic [WORD_W-1:0] memOut;
  logic              busy;
  logic              ready;
  logic              misalign_err;
  logic              range_err;

  modport master (
    output read, write, size, unsigned_ld, address, memIn,
    input  memOut, busy, ready, misalign_err, range_err
  );
  modport slave (
    input  read, write, size, unsigned_ld, address, memIn,
    output memOut, busy, ready, misalign_err, range_err
  );
endinterface

// File: rtl/dmem_lane.sv
// Byte-lane steering: store enables/shifted data and load extract/extend.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_lane,
  input  logic              i_uns,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [WORD_W-1:0] i_rword,
  output logic [3:0]        o_be,
  output logic [WORD_W-1:0] o_wdata,
  output logic [WORD_W-1:0] o_rdata
);
  logic [WORD_W-1:0] w_sh;

  always_comb begin
    o_be = 4'b0000;
    case (i_size)
      SZ_BYTE: o_be = 4'b0001 << i_lane;
      SZ_HALF: o_be = 4'b0011 << i_lane;
      SZ_WORD: o_be = 4'b1111;
      default: o_be = 4'b0000;
    endcase
  end

  assign o_wdata = i_wdata << {i_lane, 3'b000};
  assign w_sh    = i_rword >> {i_lane, 3'b000};

  always_comb begin
    o_rdata = w_sh;
    case (i_size)
      SZ_BYTE: o_rdata = {{24{~i_uns & w_sh[7]}},  w_sh[7:0]};
      SZ_HALF: o_rdata = {{16{~i_uns & w_sh[15]}}, w_sh[15:0]};
      default: o_rdata = w_sh;
    endcase
  end
endmodule

// File: rtl/dmem_wait.sv
// Data memory with programmable wait states, sub-word access and fault reporting.
module dmem_wait
  import dmem_pkg::*;
#(
  parameter int          DEPTH = 256,
  parameter int          WAIT  = 2,
  parameter logic [31:0] BASE  = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  dmem_wait_if.slave  bus
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
  localparam logic [31:0] SPAN     = 32'(DEPTH * 4);

  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic [WORD_W-1:0] r_addr, r_data, r_out;
  logic [1:0]        r_size;
  logic              r_uns, r_wr, r_mis, r_rng;
  logic [WORD_W-1:0] r_mem [DEPTH];

  logic              w_open, w_acc, w_mis, w_rng, w_done;
  logic [WORD_W-1:0] w_off, w_roff, w_wdata, w_rdata;
  logic [AW-1:0]     w_idx;
  logic [3:0]        w_be;

  // DONE accepts like IDLE so the LSU can issue back-to-back.
  assign w_open = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_acc  = w_open && (bus.read || bus.write);
  assign w_mis  = !size_aligned(bus.size, bus.address[1:0]);
  assign w_off  = bus.address - BASE;
  assign w_rng  = (w_off >= SPAN);
  assign w_roff = r_addr - BASE;
  assign w_idx  = AW'(w_roff >> 2);
  assign w_done = (r_state == S_DONE);

  dmem_lane u_lane (
    .i_size  (r_size),
    .i_lane  (r_addr[1:0]),
    .i_uns   (r_uns),
    .i_wdata (r_data),
    .i_rword (r_mem[w_idx]),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (!w_acc)              w_next = S_IDLE;
        else if (w_mis || w_rng) w_next = S_DONE;
        else if (WAIT > 0)       w_next = S_WAIT;
        else                     w_next = S_ACCESS;
      end
      S_WAIT:   if (r_cnt == 4'd0) w_next = S_ACCESS;
      S_ACCESS: w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_out   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_size  <= SZ_BYTE;
      r_uns   <= 1'b0;
      r_wr    <= 1'b0;
      r_mis   <= 1'b0;
      r_rng   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_addr <= bus.address;
        r_data <= bus.memIn;
        r_size <= bus.size;
        r_uns  <= bus.unsigned_ld;
        r_wr   <= bus.write;
        r_mis  <= w_mis;
        r_rng  <= !w_mis && w_rng;
        r_cnt  <= CNT_INIT;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == S_ACCESS && !r_wr) r_out <= w_rdata;
    end
  end

  // Array is not reset; reset still blocks a store landing on the same edge.
  always_ff @(posedge clk) begin
    if (!reset && r_state == S_ACCESS && r_wr) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  assign bus.busy         = (r_state == S_WAIT) || (r_state == S_ACCESS);
  assign bus.ready        = w_done;
  assign bus.misalign_err = w_done && r_mis;
  assign bus.range_err    = w_done && r_rng;
  assign bus.memOut       = r_out;
endmodule

// File: tb/tb_dmem_wait.sv
// Directed bench: WAIT=2 instance for function/faults/reset, WAIT=0 twin for back-to-back.
module tb_dmem_wait;
  import dmem_pkg::*;

  logic gclk = 1'b0;
  logic reset = 1'b1;
  always #5 gclk = ~gclk;

  dmem_wait_if a ();
  dmem_wait_if b ();

  // Both instances see the same request stream.
  assign b.read        = a.read;
  assign b.write       = a.write;
  assign b.size        = a.size;
  assign b.unsigned_ld = a.unsigned_ld;
  assign b.address     = a.address;
  assign b.memIn       = a.memIn;

  dmem_wait #(.DEPTH(256), .WAIT(2), .BASE(32'h0)) u_dut2 (.clk(gclk), .reset(reset), .bus(a.slave));
  dmem_wait #(.DEPTH(256), .WAIT(0), .BASE(32'h0)) u_dut0 (.clk(gclk), .reset(reset), .bus(b.slave));

  int   total = 0;
  int   bad   = 0;
  int   lat;
  logic rmis, rrng, bsy;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  // Issue one request; lat=1 is the sample just after the accepting edge.
  task automatic req(input logic wr, input logic rd, input logic [1:0] sz, input logic uns,
                     input logic [31:0] ad, input logic [31:0] dat);
    @(negedge gclk);
    a.write = wr; a.read = rd; a.size = sz; a.unsigned_ld = uns; a.address = ad; a.memIn = dat;
    @(posedge gclk); #1;
    a.read = 1'b0; a.write = 1'b0;
    bsy = a.busy;
    lat = 1;
    while (!a.ready && lat < 40) begin
      @(posedge gclk); #1;
      lat++;
    end
    rmis = a.misalign_err;
    rrng = a.range_err;
  endtask

  task automatic st(input string tag, input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] dat);
    req(1'b1, 1'b0, sz, 1'b0, ad, dat);
    chk({tag, ".lat"}, 32'(lat), 32'd4);
    chk({tag, ".flags"}, 32'({bsy, rmis, rrng}), 32'b100);
  endtask

  task automatic ld(input string tag, input logic [1:0] sz, input logic uns, input logic [31:0] ad,
                    input logic [31:0] exp);
    req(1'b0, 1'b1, sz, uns, ad, 32'h0);
    chk({tag, ".lat"}, 32'(lat), 32'd4);
    chk({tag, ".data"}, a.memOut, exp);
  endtask

  task automatic flt(input string tag, input logic wr, input logic [1:0] sz, input logic [31:0] ad,
                     input logic [1:0] flags, input logic [31:0] keep);
    req(wr, !wr, sz, 1'b0, ad, 32'hFFFF_FFFF);
    chk({tag, ".lat"}, 32'(lat), 32'd1);
    chk({tag, ".flags"}, 32'({rmis, rrng}), 32'(flags));
    chk({tag, ".keep"}, a.memOut, keep);
  endtask

  logic [31:0] b2b_ad [4];
  logic [31:0] b2b_ex [4];

  initial begin
    a.read = 1'b0; a.write = 1'b0; a.size = SZ_WORD; a.unsigned_ld = 1'b0;
    a.address = '0; a.memIn = '0;

    repeat (2) @(posedge gclk);
    #1;
    chk("rst.out", a.memOut, 32'h0);
    chk("rst.ctl", 32'({a.busy, a.ready, a.misalign_err, a.range_err}), 32'h0);
    @(negedge gclk) reset = 1'b0;

    st("st16", SZ_WORD, 32'd16, 32'h1234_5678);
    st("st24", SZ_WORD, 32'd24, 32'h89ab_cdef);
    ld("ld16", SZ_WORD, 1'b0, 32'd16, 32'h1234_5678);
    req(1'b0, 1'b1, SZ_WORD, 1'b0, 32'd20, 32'h0);
    chk("ld20.lat", 32'(lat), 32'd4);
    ld("ld24", SZ_WORD, 1'b0, 32'd24, 32'h89ab_cdef);

    st("st12", SZ_WORD, 32'd12, 32'h0bad_f00d);
    flt("st13", 1'b1, SZ_WORD, 32'd13, 2'b10, 32'h89ab_cdef);
    ld("ld12", SZ_WORD, 1'b0, 32'd12, 32'h0bad_f00d);

    st("stb17", SZ_BYTE, 32'd17, 32'hFFFF_FFAA);
    ld("ldw16", SZ_WORD, 1'b0, 32'd16, 32'h1234_AA78);
    ld("ldbs17", SZ_BYTE, 1'b0, 32'd17, 32'hFFFF_FFAA);
    ld("ldbu17", SZ_BYTE, 1'b1, 32'd17, 32'h0000_00AA);
    ld("ldhu18", SZ_HALF, 1'b1, 32'd18, 32'h0000_1234);
    ld("ldhs16", SZ_HALF, 1'b0, 32'd16, 32'hFFFF_AA78);

    flt("ld1024", 1'b0, SZ_WORD, 32'd1024, 2'b01, 32'hFFFF_AA78);
    flt("ld1025", 1'b0, SZ_WORD, 32'd1025, 2'b10, 32'hFFFF_AA78);
    flt("sz11",   1'b0, 2'b11,   32'd16,   2'b10, 32'hFFFF_AA78);
    flt("sth19",  1'b1, SZ_HALF, 32'd19,   2'b10, 32'hFFFF_AA78);

    // Reset while the store is still waiting.
    st("st40", SZ_WORD, 32'd40, 32'h4040_4040);
    @(negedge gclk);
    a.write = 1'b1; a.size = SZ_WORD; a.address = 32'd40; a.memIn = 32'hDEAD_BEEF;
    @(posedge gclk); #1;
    a.write = 1'b0;
    chk("rstw.busy", 32'(a.busy), 32'd1);
    @(negedge gclk) reset = 1'b1;
    @(posedge gclk); #1;
    chk("rstw.out", a.memOut, 32'h0);
    chk("rstw.ctl", 32'({a.busy, a.ready, a.misalign_err, a.range_err}), 32'h0);
    @(negedge gclk) reset = 1'b0;
    ld("ld40a", SZ_WORD, 1'b0, 32'd40, 32'h4040_4040);

    // Reset on the very edge the store would commit.
    @(negedge gclk);
    a.write = 1'b1; a.size = SZ_WORD; a.address = 32'd40; a.memIn = 32'hCAFE_F00D;
    @(posedge gclk); #1;
    a.write = 1'b0;
    @(posedge gclk);
    @(posedge gclk); #1;
    chk("rsta.busy", 32'(a.busy), 32'd1);
    @(negedge gclk) reset = 1'b1;
    @(posedge gclk); #1;
    chk("rsta.ctl", 32'({a.busy, a.ready}), 32'h0);
    @(negedge gclk) reset = 1'b0;
    ld("ld40b", SZ_WORD, 1'b0, 32'd40, 32'h4040_4040);

    req(1'b1, 1'b1, SZ_WORD, 1'b0, 32'd44, 32'h5566_7788);
    chk("rdwr.lat", 32'(lat), 32'd4);
    chk("rdwr.keep", a.memOut, 32'h4040_4040);
    ld("ld44", SZ_WORD, 1'b0, 32'd44, 32'h5566_7788);

    // WAIT=0 twin: requests placed in every DONE cycle.
    b2b_ad[0] = 32'd16; b2b_ex[0] = 32'h1234_AA78;
    b2b_ad[1] = 32'd24; b2b_ex[1] = 32'h89ab_cdef;
    b2b_ad[2] = 32'd44; b2b_ex[2] = 32'h5566_7788;
    b2b_ad[3] = 32'd12; b2b_ex[3] = 32'h0bad_f00d;
    @(negedge gclk);
    a.read = 1'b1; a.size = SZ_WORD; a.unsigned_ld = 1'b0; a.address = b2b_ad[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge gclk); #1;
      a.read = 1'b0;
      chk("b2b.gap", 32'(b.ready), 32'd0);
      @(posedge gclk); #1;
      chk("b2b.rdy", 32'(b.ready), 32'd1);
      chk("b2b.data", b.memOut, b2b_ex[i]);
      if (i < 3) begin
        a.read = 1'b1;
        a.address = b2b_ad[i+1];
      end
    end

    repeat (8) @(posedge gclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
